bp_cfg_loader_seq: RTL and testbench
====================================

BP_CFG_LOADER_SEQ -- requirements
Module: bp_cfg_loader_seq

Interface
REQ-001 SHALL have parameter num_core_p, default 2, meaning number of cores to configure (1..16).
REQ-002 SHALL have parameter cfg_addr_width_p, default 16, meaning config register address width.
REQ-003 SHALL have parameter cfg_data_width_p, default 32, meaning config write data width.
REQ-004 SHALL have parameter max_credits_p, default 4, meaning max unacknowledged writes (power of 2, >=2).
REQ-005 SHALL have ports in this order:
- clk_i  in  1  single clock, all state on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- cce_mode_i  in  1  CCE mode value written to each core (0 uncached, 1 normal), sampled per write.
- cfg_v_o  out  1  config write valid.
- cfg_ready_i  in  1  downstream accepts write when cfg_v_o & cfg_ready_i.
- cfg_core_o  out  clog2(num_core_p) (min 1)  target core index.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- cfg_resp_v_i  in  1  one write acknowledgement per cycle when high.
- credits_o  out  clog2(max_credits_p+1)  current outstanding write count.
- done_o  out  1  sequence complete, all writes acknowledged.
- error_o  out  1  sticky: acknowledgement received with zero outstanding.

Function
REQ-006 SHALL sequence states e_freeze, e_core_id, e_mode, e_fence, e_unfreeze, e_drain, e_done, in that order.
REQ-007 In each of e_freeze, e_core_id, e_mode, e_unfreeze, SHALL issue one write per core, core index 0 to num_core_p-1, then advance on the handshake of the last core.
REQ-008 Writes SHALL be: e_freeze addr 0x0002 data 1; e_core_id addr 0x0004 data core index; e_mode addr 0x0008 data cce_mode_i; e_unfreeze addr 0x0002 data 0.
REQ-009 cfg_v_o SHALL be high only in write states and only when credits_o < max_credits_p.
REQ-010 Once cfg_v_o is high, addr/data/core SHALL hold stable until handshake (no retraction), except via reset. cce_mode_i changes during a pending e_mode write SHALL NOT alter cfg_data_o; it is latched on entering the write.
REQ-011 Core index SHALL advance only on handshake and wrap to 0 on phase change.
REQ-012 Credit counter: +1 on handshake, -1 on cfg_resp_v_i; simultaneous both -> unchanged; credits_o is registered.
REQ-013 cfg_resp_v_i with credits_o==0 and no same-cycle handshake SHALL set error_o and leave counter at 0.
REQ-014 e_fence SHALL issue no writes and advance to e_unfreeze the cycle after credits_o==0 (including when 0 on entry).
REQ-015 e_drain SHALL advance to e_done when credits_o==0; e_done SHALL be terminal until reset.
REQ-016 done_o SHALL be high exactly in e_done; registered.
REQ-017 Throughput SHALL be one write per cycle while cfg_ready_i high and credits available; first cfg_v_o one cycle after reset release.

Reset
REQ-018 reset_n_i low at a clock edge SHALL force state e_freeze, core index 0, credits 0, error_o 0, done_o 0, cfg_v_o 0, cfg_core_o/addr/data 0.
REQ-019 Reset mid-sequence SHALL abandon outstanding writes; late acknowledgements after reset SHALL flag error_o per REQ-013.

Verification
REQ-020 num_core_p=2, ready=1, resp returned 1 cycle after each handshake -> 8 writes in order (0x2/1 c0,c1; 0x4/0,1; 0x8/mode; 0x2/0 c0,c1), done_o high with credits_o=0.
REQ-021 max_credits_p=4, no responses -> cfg_v_o drops after 4 handshakes, credits_o=4; one response -> exactly one more write issued.
REQ-022 Responses withheld until after last e_mode write -> no unfreeze write issued until credits_o=0; first 0x2/0 write follows one cycle after zero.
REQ-023 cfg_ready_i low 5 cycles with cfg_v_o high while cce_mode_i toggles -> addr/data/core stable throughout.
REQ-024 Simultaneous handshake and response at credits_o=2 -> stays 2; response at credits_o=0 idle -> error_o=1 sticky.
REQ-025 Reset asserted during e_core_id -> next cycle all outputs 0, then sequence restarts with 0x2/1 to core 0.

Source files
------------

// File: rtl/bp_cfg_loader_seq.sv
// Boot-time configuration loader: freezes each core, writes core id and CCE mode,
// waits for all acknowledgements, unfreezes the cores, then drains and stops.
//
// state      | meaning
// e_freeze   | write freeze=1 (addr 0x2) to every core
// e_core_id  | write core index (addr 0x4) to every core
// e_mode     | write CCE mode (addr 0x8) to every core
// e_fence    | no writes; wait for all outstanding writes to be acknowledged
// e_unfreeze | write freeze=0 (addr 0x2) to every core
// e_drain    | wait for the last acknowledgements
// e_done     | terminal, done_o high
module bp_cfg_loader_seq #(
   parameter int num_core_p       = 2,
   parameter int cfg_addr_width_p = 16,
   parameter int cfg_data_width_p = 32,
   parameter int max_credits_p    = 4,
   localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
   localparam int cred_w_lp = $clog2(max_credits_p + 1)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        cce_mode_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [core_w_lp-1:0]        cfg_core_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_resp_v_i,
   output logic [cred_w_lp-1:0]        credits_o,
   output logic                        done_o,
   output logic                        error_o
);

   typedef enum logic [2:0] {
      e_freeze, e_core_id, e_mode, e_fence, e_unfreeze, e_drain, e_done
   } state_e;

   localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);
   localparam logic [cred_w_lp-1:0] max_cred_lp  = cred_w_lp'(max_credits_p);

   state_e                      state_q, state_n;
   logic [core_w_lp-1:0]        core_q, core_n;
   logic [cred_w_lp-1:0]        credits_q, credits_n;
   logic                        error_q, error_n;
   logic                        v_q, v_n;
   logic [core_w_lp-1:0]        out_core_q, out_core_n;
   logic [cfg_addr_width_p-1:0] addr_q, addr_n;
   logic [cfg_data_width_p-1:0] data_q, data_n;
   logic                        hs;
   logic                        write_phase_n;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= e_freeze;
         core_q     <= '0;
         credits_q  <= '0;
         error_q    <= 1'b0;
         v_q        <= 1'b0;
         out_core_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_n;
         core_q     <= core_n;
         credits_q  <= credits_n;
         error_q    <= error_n;
         v_q        <= v_n;
         out_core_q <= out_core_n;
         addr_q     <= addr_n;
         data_q     <= data_n;
      end
   end

   always_comb begin
      hs         = v_q & cfg_ready_i;
      credits_n  = credits_q;
      error_n    = error_q;
      state_n    = state_q;
      core_n     = core_q;
      v_n        = v_q;
      out_core_n = out_core_q;
      addr_n     = addr_q;
      data_n     = data_q;

      if (hs && !cfg_resp_v_i) begin
         credits_n = credits_q + cred_w_lp'(1);
      end else if (!hs && cfg_resp_v_i) begin
         if (credits_q == '0) error_n = 1'b1;
         else                 credits_n = credits_q - cred_w_lp'(1);
      end

      case (state_q)
         e_fence: if (credits_q == '0) state_n = e_unfreeze;
         e_drain: if (credits_q == '0) state_n = e_done;
         default: ;
      endcase

      // state/core here point at the next write to offer, not the one on the bus
      if (hs) begin
         if (core_q == last_core_lp) begin
            core_n = '0;
            case (state_q)
               e_freeze:   state_n = e_core_id;
               e_core_id:  state_n = e_mode;
               e_mode:     state_n = e_fence;
               e_unfreeze: state_n = e_drain;
               default:    ;
            endcase
         end else begin
            core_n = core_q + core_w_lp'(1);
         end
      end

      write_phase_n = (state_n == e_freeze) || (state_n == e_core_id) ||
                      (state_n == e_mode)   || (state_n == e_unfreeze);

      // a pending write holds its fields; mode is captured only when a write is loaded
      if (!v_q || hs) begin
         v_n = write_phase_n && (credits_n < max_cred_lp);
         if (v_n) begin
            out_core_n = core_n;
            case (state_n)
               e_freeze: begin
                  addr_n = cfg_addr_width_p'(16'h0002);
                  data_n = cfg_data_width_p'(1);
               end
               e_core_id: begin
                  addr_n = cfg_addr_width_p'(16'h0004);
                  data_n = cfg_data_width_p'(core_n);
               end
               e_mode: begin
                  addr_n = cfg_addr_width_p'(16'h0008);
                  data_n = cfg_data_width_p'(cce_mode_i);
               end
               default: begin
                  addr_n = cfg_addr_width_p'(16'h0002);
                  data_n = '0;
               end
            endcase
         end
      end
   end

   assign cfg_v_o    = v_q;
   assign cfg_core_o = out_core_q;
   assign cfg_addr_o = addr_q;
   assign cfg_data_o = data_q;
   assign credits_o  = credits_q;
   assign error_o    = error_q;
   assign done_o     = (state_q == e_done);

endmodule

// File: tb/tb_bp_cfg_loader_seq.sv
// Self-checking bench for bp_cfg_loader_seq: cycle table for a full sequence,
// directed corner cases, and randomized runs against a write-list/credit model.
module tb_bp_cfg_loader_seq;
   localparam int NC = 2;
   localparam int MC = 4;
   localparam int NW = 4 * NC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cce_mode = 1'b0;
   logic        cfg_ready = 1'b0;
   logic        cfg_resp_v = 1'b0;
   logic        cfg_v;
   logic [0:0]  cfg_core;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_data;
   logic [2:0]  credits;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   bp_cfg_loader_seq #(
      .num_core_p(NC), .cfg_addr_width_p(16), .cfg_data_width_p(32), .max_credits_p(MC)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .cce_mode_i(cce_mode),
      .cfg_v_o(cfg_v), .cfg_ready_i(cfg_ready), .cfg_core_o(cfg_core),
      .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data), .cfg_resp_v_i(cfg_resp_v),
      .credits_o(credits), .done_o(done), .error_o(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      cfg_ready  = 1'b0;
      cfg_resp_v = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
   endtask

   // expected write list derived from the phase rules: phase = idx / NC, core = idx % NC
   function automatic logic [15:0] exp_addr(input int idx);
      case (idx / NC)
         0: return 16'h0002;
         1: return 16'h0004;
         2: return 16'h0008;
         default: return 16'h0002;
      endcase
   endfunction

   function automatic logic [31:0] exp_data(input int idx, input logic mode);
      case (idx / NC)
         0: return 32'd1;
         1: return 32'(idx % NC);
         2: return 32'(mode);
         default: return 32'd0;
      endcase
   endfunction

   typedef struct {
      logic        ready, resp;
      logic        v;
      logic [15:0] addr;
      logic [31:0] data;
      logic        core;
      logic [2:0]  cr;
      logic        dn;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rs, input logic v, input logic [15:0] a,
                               input logic [31:0] d, input logic c, input logic [2:0] cr,
                               input logic dn);
      vec_t t;
      t.ready = r; t.resp = rs; t.v = v; t.addr = a; t.data = d; t.core = c; t.cr = cr; t.dn = dn;
      return t;
   endfunction

   vec_t tbl[15];

   initial begin
      logic [15:0] cap_addr;
      logic [31:0] cap_data;
      logic [0:0]  cap_core;
      int          hs_cnt;
      bit          found;

      // full sequence, ready=1, each ack one cycle after its handshake, mode=1
      tbl[0]  = mk(1, 0, 0, 16'h0, 32'h0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 1, 16'h2, 32'h1, 0, 0, 0);
      tbl[2]  = mk(1, 1, 1, 16'h2, 32'h1, 1, 1, 0);
      tbl[3]  = mk(1, 1, 1, 16'h4, 32'h0, 0, 1, 0);
      tbl[4]  = mk(1, 1, 1, 16'h4, 32'h1, 1, 1, 0);
      tbl[5]  = mk(1, 1, 1, 16'h8, 32'h1, 0, 1, 0);
      tbl[6]  = mk(1, 1, 1, 16'h8, 32'h1, 1, 1, 0);
      tbl[7]  = mk(1, 1, 0, 16'h0, 32'h0, 0, 1, 0);
      tbl[8]  = mk(1, 0, 0, 16'h0, 32'h0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 1, 16'h2, 32'h0, 0, 0, 0);
      tbl[10] = mk(1, 1, 1, 16'h2, 32'h0, 1, 1, 0);
      tbl[11] = mk(1, 1, 0, 16'h0, 32'h0, 0, 1, 0);
      tbl[12] = mk(1, 0, 0, 16'h0, 32'h0, 0, 0, 0);
      tbl[13] = mk(1, 0, 0, 16'h0, 32'h0, 0, 0, 1);
      tbl[14] = mk(1, 0, 0, 16'h0, 32'h0, 0, 0, 1);

      cce_mode = 1'b1;
      do_reset();
      check("reset_outputs", {cfg_v, cfg_core, cfg_addr, credits, done, error}, 32'h0);
      check("reset_data", cfg_data, 32'h0);
      for (int i = 0; i < 15; i++) begin
         cfg_ready  = tbl[i].ready;
         cfg_resp_v = tbl[i].resp;
         check($sformatf("tbl%0d_v", i), cfg_v, tbl[i].v);
         check($sformatf("tbl%0d_credits", i), credits, tbl[i].cr);
         check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
         if (tbl[i].v) begin
            check($sformatf("tbl%0d_addr", i), cfg_addr, tbl[i].addr);
            check($sformatf("tbl%0d_data", i), cfg_data, tbl[i].data);
            check($sformatf("tbl%0d_core", i), cfg_core, tbl[i].core);
         end
         step();
      end
      check("tbl_error", error, 0);

      // credit limit: no acks -> four writes, then one ack lets exactly one more through
      do_reset();
      cfg_ready = 1'b1;
      hs_cnt = 0;
      repeat (9) begin
         if (cfg_v && cfg_ready) hs_cnt++;
         step();
      end
      check("limit_v", cfg_v, 0);
      check("limit_credits", credits, 4);
      check("limit_hs", hs_cnt, 4);
      cfg_resp_v = 1'b1;
      step();
      cfg_resp_v = 1'b0;
      repeat (6) begin
         if (cfg_v && cfg_ready) hs_cnt++;
         step();
      end
      check("limit_one_more_hs", hs_cnt, 5);
      check("limit_credits_after", credits, 4);
      check("limit_v_after", cfg_v, 0);

      // simultaneous handshake and ack at credits=2, then ack with nothing outstanding
      do_reset();
      cfg_ready = 1'b1;
      repeat (3) step();
      check("simul_pre_credits", credits, 2);
      cfg_resp_v = 1'b1;
      step();
      check("simul_credits", credits, 2);
      cfg_ready = 1'b0;
      repeat (2) step();
      check("simul_drained", credits, 0);
      check("simul_no_error_yet", error, 0);
      step();
      cfg_resp_v = 1'b0;
      check("underflow_error", error, 1);
      check("underflow_credits", credits, 0);
      repeat (3) step();
      check("error_sticky", error, 1);

      // stall on a pending mode write while cce_mode toggles
      do_reset();
      cce_mode = 1'b0;
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (cfg_v && cfg_addr == 16'h0008) begin found = 1; break; end
         cfg_ready  = 1'b1;
         cfg_resp_v = (credits != 0);
         step();
      end
      cfg_ready  = 1'b0;
      cfg_resp_v = 1'b0;
      check("stall_reach_mode", found, 1);
      check("stall_first_data", cfg_data, 0);
      cap_addr = cfg_addr; cap_data = cfg_data; cap_core = cfg_core;
      for (int c = 0; c < 5; c++) begin
         cce_mode = ~cce_mode;
         step();
         check($sformatf("stall%0d_hold", c), {cfg_v, 15'h0, cfg_addr},
               {1'b1, 15'h0, cap_addr});
         check($sformatf("stall%0d_data", c), cfg_data, cap_data);
         check($sformatf("stall%0d_core", c), cfg_core, cap_core);
      end
      cfg_ready = 1'b1;
      step();
      cfg_ready = 1'b0;
      check("stall_next_addr", cfg_addr, 16'h0008);
      check("stall_next_data", cfg_data, 32'(cce_mode));
      check("stall_next_core", cfg_core, 1);

      // reset in the middle of core_id, then a late ack
      do_reset();
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (cfg_v && cfg_addr == 16'h0004) begin found = 1; break; end
         cfg_ready  = 1'b1;
         cfg_resp_v = (credits != 0);
         step();
      end
      check("midreset_reach_core_id", found, 1);
      cfg_ready  = 1'b0;
      cfg_resp_v = 1'b0;
      reset_n    = 1'b0;
      step();
      check("midreset_outputs", {cfg_v, cfg_core, cfg_addr, credits, done, error}, 32'h0);
      check("midreset_data", cfg_data, 0);
      reset_n = 1'b1;
      check("restart_c0_idle", cfg_v, 0);
      step();
      check("restart_v", cfg_v, 1);
      check("restart_addr", cfg_addr, 16'h0002);
      check("restart_data", cfg_data, 1);
      check("restart_core", cfg_core, 0);
      cfg_resp_v = 1'b1;
      step();
      cfg_resp_v = 1'b0;
      check("late_ack_error", error, 1);
      check("late_ack_credits", credits, 0);

      // randomized runs against the write-list / credit model
      for (int run = 0; run < 15; run++) begin
         logic mode;
         int   idx, outst, cyc;
         bit   held, hs;
         do_reset();
         mode = 1'($urandom_range(0, 1));
         cce_mode = mode;
         idx = 0; outst = 0; held = 0; cyc = 0;
         while (!done && cyc < 600) begin
            cfg_ready  = ($urandom_range(0, 3) != 0);
            cfg_resp_v = (outst > 0) && ($urandom_range(0, 1) == 1);
            check("rand_credits", credits, outst);
            if (cfg_v) check("rand_credit_limit", (outst < MC), 1);
            if (held) begin
               check("rand_hold", {cfg_v, 15'h0, cfg_addr}, {1'b1, 15'h0, cap_addr});
               check("rand_hold_data", cfg_data, cap_data);
               check("rand_hold_core", cfg_core, cap_core);
            end
            hs = cfg_v && cfg_ready;
            if (hs) begin
               if (idx < NW) begin
                  check("rand_addr", cfg_addr, exp_addr(idx));
                  check("rand_data", cfg_data, exp_data(idx, mode));
                  check("rand_core", cfg_core, idx % NC);
                  if (idx == 3 * NC) check("rand_fence_outstanding", outst, 0);
               end else begin
                  check("rand_extra_write", idx, NW - 1);
               end
               idx++;
            end
            held = cfg_v && !hs;
            cap_addr = cfg_addr; cap_data = cfg_data; cap_core = cfg_core;
            outst = outst + (hs ? 1 : 0) - (cfg_resp_v ? 1 : 0);
            step();
            cyc++;
         end
         check("rand_done", done, 1);
         check("rand_writes", idx, NW);
         check("rand_final_credits", credits, 0);
         check("rand_no_error", error, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
